// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write side.
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic              killed;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_queue.sv
// Circular load queue holding loads that lost write-port arbitration.
// Entries whose destination is overwritten by a younger ALU result are marked killed in place.
module wb_load_queue
  import rf_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_rd,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_kill_en,
  input  logic [ADDR_W-1:0] i_kill_rd,
  output wb_entry_t         o_head,
  output logic [CW-1:0]     o_count
);

  wb_entry_t         r_entries [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  assign o_head  = r_entries[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_en && r_entries[i].valid && (r_entries[i].rd == i_kill_rd)) begin
          r_entries[i].killed <= 1'b1;
        end
      end
      if (i_pop) begin
        r_entries[r_rptr].valid <= 1'b0;
        r_rptr                  <= r_rptr + 1'b1;
      end
      // Push is never aimed at the slot being popped: pushes need a non-full queue.
      if (i_push) begin
        r_entries[r_wptr] <= '{valid: 1'b1, killed: 1'b0, rd: i_push_rd, data: i_push_data};
        r_wptr            <= r_wptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write-port driver: ALU results first, then queued loads, then bypassed loads.
// Optional WB_FORWARD_EN adds two combinational forwarding taps off the registered write port.
module reg_writeback_unit
  import rf_pkg::*;
#(
  parameter int  DATA_W   = rf_pkg::DATA_W,
  parameter int  ADDR_W   = rf_pkg::ADDR_W,
  parameter int  LQ_DEPTH = 2,
  localparam int CW       = $clog2(LQ_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
`ifdef WB_FORWARD_EN
  input  logic [ADDR_W-1:0] fwd_rs_1,
  input  logic [ADDR_W-1:0] fwd_rs_2,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
`endif
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  output logic              sig_reg_write,
  output logic [CW-1:0]     lq_count
);

  localparam logic [CW-1:0] LQ_FULL = CW'(LQ_DEPTH);

  wb_entry_t         w_head;
  logic [CW-1:0]     w_count;
  logic              w_alu_eff;
  logic              w_accept;
  logic              w_load_ok;
  logic              w_pop;
  logic              w_push;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;

  logic              r_we;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;

  assign mem_ready = !reset && (w_count < LQ_FULL);
  assign w_accept  = mem_valid && mem_ready;
  assign w_alu_eff = alu_valid && (alu_rd != REG_ZERO);
  // A load to the same rd as a concurrent ALU result is older and therefore dead.
  assign w_load_ok = w_accept && (mem_rd != REG_ZERO) && !(w_alu_eff && (mem_rd == alu_rd));

  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_rd   = r_rd;
    w_sel_data = r_data;
    w_pop      = 1'b0;
    w_push     = w_load_ok;
    if (w_alu_eff) begin
      w_sel_we   = 1'b1;
      w_sel_rd   = alu_rd;
      w_sel_data = alu_data;
    end else if (w_head.valid) begin
      w_pop = 1'b1;
      if (!w_head.killed) begin
        w_sel_we   = 1'b1;
        w_sel_rd   = w_head.rd;
        w_sel_data = w_head.data;
      end
    end else if (w_load_ok) begin
      w_push     = 1'b0;
      w_sel_we   = 1'b1;
      w_sel_rd   = mem_rd;
      w_sel_data = mem_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_sel_we;
      if (w_sel_we) begin
        r_rd   <= w_sel_rd;
        r_data <= w_sel_data;
      end
    end
  end

  wb_load_queue #(
    .DEPTH(LQ_DEPTH)
  ) u_lq (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_rd   (mem_rd),
    .i_push_data (mem_data),
    .i_pop       (w_pop),
    .i_kill_en   (w_alu_eff),
    .i_kill_rd   (alu_rd),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign write_register = r_rd;
  assign write_data     = r_data;
  assign sig_reg_write  = r_we;
  assign lq_count       = w_count;

`ifdef WB_FORWARD_EN
  assign fwd_hit_1  = r_we && (r_rd == fwd_rs_1) && (fwd_rs_1 != REG_ZERO);
  assign fwd_hit_2  = r_we && (r_rd == fwd_rs_2) && (fwd_rs_2 != REG_ZERO);
  assign fwd_data_1 = fwd_hit_1 ? r_data : '0;
  assign fwd_data_2 = fwd_hit_2 ? r_data : '0;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit: directed cases plus randomized traffic vs a queue model.
module tb_reg_writeback_unit;

  localparam int LQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        sig_reg_write;
  logic [1:0]  lq_count;
`ifdef WB_FORWARD_EN
  logic [4:0]  fwd_rs_1, fwd_rs_2;
  logic        fwd_hit_1, fwd_hit_2;
  logic [31:0] fwd_data_1, fwd_data_2;
`endif

  always #5 clk = ~clk;

  reg_writeback_unit #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
`ifdef WB_FORWARD_EN
    .fwd_rs_1(fwd_rs_1), .fwd_rs_2(fwd_rs_2),
    .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
`endif
    .write_register(write_register), .write_data(write_data),
    .sig_reg_write(sig_reg_write), .lq_count(lq_count)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          killed;
  } ent_t;

  ent_t        mq[$];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Spec-level model of one clock edge given the inputs presented before it.
  task automatic model_edge(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                            input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    bit   accept, alu, load_ok;
    ent_t h;
    accept  = mv && (mq.size() < LQ_DEPTH);
    alu     = av && (ard != 0);
    load_ok = accept && (mrd != 0) && !(alu && mrd == ard);
    m_we    = 1'b0;
    if (alu) begin
      foreach (mq[i]) if (mq[i].rd == ard) mq[i].killed = 1'b1;
      m_we = 1'b1; m_rd = ard; m_data = ad;
      if (load_ok) mq.push_back('{mrd, md, 1'b0});
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      if (!h.killed) begin m_we = 1'b1; m_rd = h.rd; m_data = h.data; end
      if (load_ok) mq.push_back('{mrd, md, 1'b0});
    end else if (load_ok) begin
      m_we = 1'b1; m_rd = mrd; m_data = md;
    end
  endtask

  task automatic compare_outputs();
    chk("sig_reg_write", 32'(sig_reg_write), 32'(m_we));
    chk("write_register", 32'(write_register), 32'(m_rd));
    chk("write_data", write_data, m_data);
    chk("lq_count", 32'(lq_count), 32'(mq.size()));
`ifdef WB_FORWARD_EN
    chk("fwd_hit_1", 32'(fwd_hit_1), 32'(m_we && m_rd == fwd_rs_1 && fwd_rs_1 != 0));
    chk("fwd_data_1", fwd_data_1, (m_we && m_rd == fwd_rs_1 && fwd_rs_1 != 0) ? m_data : 32'h0);
    chk("fwd_hit_2", 32'(fwd_hit_2), 32'(m_we && m_rd == fwd_rs_2 && fwd_rs_2 != 0));
    chk("fwd_data_2", fwd_data_2, (m_we && m_rd == fwd_rs_2 && fwd_rs_2 != 0) ? m_data : 32'h0);
`endif
  endtask

  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
`ifdef WB_FORWARD_EN
    fwd_rs_1 = ($urandom_range(0, 1) == 1) ? m_rd : 5'($urandom_range(0, 7));
    fwd_rs_2 = 5'($urandom_range(0, 7));
`endif
    #1;
    chk("mem_ready", 32'(mem_ready), 32'(mq.size() < LQ_DEPTH));
    model_edge(av, ard, ad, mv, mrd, md);
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Reset pulse that lands between clock edges; outputs must clear immediately.
  task automatic async_reset();
    @(negedge clk);
    alu_valid = 1'b0; mem_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_we", 32'(sig_reg_write), 32'h0);
    chk("rst_addr", 32'(write_register), 32'h0);
    chk("rst_data", write_data, 32'h0);
    chk("rst_count", 32'(lq_count), 32'h0);
    chk("rst_ready", 32'(mem_ready), 32'h0);
    mq.delete();
    m_we = 1'b0; m_rd = '0; m_data = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
`ifdef WB_FORWARD_EN
    fwd_rs_1 = '0; fwd_rs_2 = '0;
`endif
    m_we = 1'b0; m_rd = '0; m_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_we", 32'(sig_reg_write), 32'h0);
    chk("init_addr", 32'(write_register), 32'h0);
    chk("init_data", write_data, 32'h0);
    chk("init_count", 32'(lq_count), 32'h0);
    chk("init_ready", 32'(mem_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_ready", 32'(mem_ready), 32'h1);

    // ALU only, including the r0 discard
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    chk("alu_we", 32'(sig_reg_write), 32'h1);
    chk("alu_addr", 32'(write_register), 32'd5);
    chk("alu_data", write_data, 32'hDEADBEEF);
    step(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'h0);
    chk("r0_we", 32'(sig_reg_write), 32'h0);
    chk("r0_hold", write_data, 32'hDEADBEEF);

    // ALU/load conflict: load waits one cycle in the queue
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h11);
    chk("cf_addr", 32'(write_register), 32'd3);
    chk("cf_cnt1", 32'(lq_count), 32'd1);
    idle();
    chk("cf_addr2", 32'(write_register), 32'd7);
    chk("cf_data2", write_data, 32'h11);
    chk("cf_cnt0", 32'(lq_count), 32'd0);

    // Backpressure: four ALU cycles while loads are offered
    for (int i = 0; i < 4; i++) step(1'b1, 5'(10 + i), 32'(i), 1'b1, 5'(20 + i), 32'(100 + i));
    chk("bp_full", 32'(lq_count), 32'd2);
    chk("bp_ready", 32'(mem_ready), 32'd0);
    idle();
    chk("bp_d0", 32'(write_register), 32'd20);
    idle();
    chk("bp_d1", 32'(write_register), 32'd21);
    chk("bp_d1v", write_data, 32'd101);
    idle();
    chk("bp_empty_we", 32'(sig_reg_write), 32'h0);

    // Kill of a queued load, then same-cycle conflict
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h55);
    step(1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 32'h0);
    chk("kill_data", write_data, 32'hAA);
    idle();
    chk("kill_nowrite", 32'(sig_reg_write), 32'h0);
    chk("kill_cnt", 32'(lq_count), 32'h0);
    step(1'b1, 5'd9, 32'hBB, 1'b1, 5'd9, 32'hCC);
    chk("same_data", write_data, 32'hBB);
    idle();
    chk("same_nowrite", 32'(sig_reg_write), 32'h0);

    // Reset with two queued loads
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    step(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4);
    chk("pre_rst_cnt", 32'(lq_count), 32'd2);
    async_reset();
    idle();
    chk("post_rst_we", 32'(sig_reg_write), 32'h0);

    // Randomized traffic over a small register range to force conflicts
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else step(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom(),
                ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
